// File: rtl/sram_ctl_32kx12_pkg.sv
// Shared definitions for the PDP-8 memory subsystem: sequencer state
// encoding, default RAM geometry and default strobe timing.
package sram_ctl_32kx12_pkg;

  localparam int ADDR_W_DEF    = 15;
  localparam int DATA_W_DEF    = 12;
  localparam int SETUP_CYC_DEF = 1;
  localparam int WE_CYC_DEF    = 2;
  localparam int RD_CYC_DEF    = 2;

  // Dwell timer width; every dwell parameter must fit below 2**TMR_W.
  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_SETUP  = 3'd1,
    ST_W_PULSE  = 3'd2,
    ST_W_HOLD   = 3'd3,
    ST_R_ACCESS = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/sram_ctl_32kx12_timer.sv
// Loadable down-counter with zero flag; times the dwell of each sequencer
// state. A load of N-1 gives a dwell of N cycles before zero is seen.
module sram_ctl_timer
  import sram_ctl_32kx12_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority; otherwise count down and stick at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_ctl_32kx12.sv
// Synchronous initiator for the 32Kx12 asynchronous SRAM. Turns single-cycle
// bus requests into sequenced A/DI/CE_N/WE_N strobes, captures DO, and runs a
// hardware clear sweep that zeroes the whole array.
//
// Handshake: req is sampled only while busy=0 (IDLE); the edge that samples
// req=1 accepts the request and latches addr/wdata. ack pulses for exactly one
// cycle when the access completes, after which the block is IDLE again on the
// following cycle. Requests arriving while busy=1 are dropped, not queued.
module sram_ctl_32kx12
  import sram_ctl_32kx12_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int WE_CYC    = WE_CYC_DEF,
  parameter int RD_CYC    = RD_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do,
  output logic              ram_ce_n,
  output logic              ram_we_n
);

  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] WE_LD    = TMR_W'(WE_CYC - 1);
  localparam logic [TMR_W-1:0] RD_LD    = TMR_W'(RD_CYC - 1);

  state_t            state;
  logic              sweep;
  // One extra bit so "all words written" is the MSB, never a wrap to zero.
  logic [ADDR_W:0]   clr_cnt;
  logic [ADDR_W:0]   clr_next;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_zero;

  assign clr_next = clr_cnt + (ADDR_W + 1)'(1);

  sram_ctl_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Reload the dwell timer on every transition into a timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        if (clr) begin
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end else if (req) begin
          tmr_load = 1'b1;
          tmr_val  = wr ? SETUP_LD : RD_LD;
        end
      end
      ST_W_SETUP: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = WE_LD;
        end
      end
      ST_DONE: begin
        if (sweep) begin
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      default: ;
    endcase
  end

  // Sequencer: strobes, address/data registers, read capture and sweep count.
  // ram_a/ram_di are only ever updated on edges where WE_N is high on both
  // sides, because the RAM is level-sensitive to address under a low WE_N.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      sweep    <= 1'b0;
      clr_cnt  <= '0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      rdata    <= '0;
      ram_a    <= '0;
      ram_di   <= '0;
      ram_ce_n <= 1'b1;
      ram_we_n <= 1'b1;
    end else begin
      ack      <= 1'b0;
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr) begin
            sweep    <= 1'b1;
            clr_cnt  <= '0;
            ram_a    <= '0;
            ram_di   <= '0;
            ram_ce_n <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_W_SETUP;
          end else if (req) begin
            ram_a    <= addr;
            ram_di   <= wdata;
            ram_ce_n <= 1'b0;
            busy     <= 1'b1;
            state    <= wr ? ST_W_SETUP : ST_R_ACCESS;
          end
        end
        ST_W_SETUP: begin
          if (tmr_zero) begin
            ram_we_n <= 1'b0;
            state    <= ST_W_PULSE;
          end
        end
        ST_W_PULSE: begin
          if (tmr_zero) begin
            ram_we_n <= 1'b1;
            state    <= ST_W_HOLD;
          end
        end
        ST_W_HOLD: begin
          ram_ce_n <= 1'b1;
          state    <= ST_DONE;
          if (sweep) begin
            if (clr_next[ADDR_W]) begin
              clr_done <= 1'b1;
              sweep    <= 1'b0;
              clr_cnt  <= '0;
            end else begin
              clr_cnt  <= clr_next;
            end
          end else begin
            ack <= 1'b1;
          end
        end
        ST_R_ACCESS: begin
          if (tmr_zero) begin
            rdata    <= ram_do;
            ram_ce_n <= 1'b1;
            ack      <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Mid-sweep, DONE is the CE_N-high gap before the next word.
          if (sweep) begin
            ram_a    <= clr_cnt[ADDR_W-1:0];
            ram_ce_n <= 1'b0;
            state    <= ST_W_SETUP;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          ram_ce_n <= 1'b1;
          ram_we_n <= 1'b1;
          busy     <= 1'b0;
          sweep    <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctl_32kx12.sv
// Bench for sram_ctl_32kx12 with a level-sensitive RAM model and a word-array
// reference of expected memory contents. Geometry is reduced to 4K words so
// the clear sweeps stay short.
module tb_sram_ctl_32kx12;

  localparam int AW    = 12;
  localparam int DW    = 12;
  localparam int SC    = 1;
  localparam int WC    = 2;
  localparam int RC    = 2;
  localparam int WORDS = 1 << AW;
  localparam int W_LAT = SC + WC + 2;
  localparam int R_LAT = RC + 1;
  localparam logic [AW-1:0] TOP = '1;

  logic          clk = 1'b0;
  logic          reset_n, req, wr, clr;
  logic [AW-1:0] addr, ram_a;
  logic [DW-1:0] wdata, rdata, ram_di, ram_do;
  logic          ack, busy, clr_done, ram_ce_n, ram_we_n;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0, done_cnt = 0, low_run = 0, last_low = 0, mon_viol = 0;

  logic [DW-1:0] ram     [WORDS];
  logic [DW-1:0] ref_mem [WORDS];
  logic [DW-1:0] last_rd;
  bit            ram_ready = 1'b0;

  always #5 clk = ~clk;

  sram_ctl_32kx12 #(
    .ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(SC), .WE_CYC(WC), .RD_CYC(RC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .addr(addr),
    .wdata(wdata), .clr(clr), .ack(ack), .rdata(rdata), .busy(busy),
    .clr_done(clr_done), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do),
    .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'((i * 37 + 5) ^ 'o5252);
  endfunction

  // RAM model: asynchronous read, write while CE_N and WE_N are both low.
  assign ram_do = ram[ram_a];
  always @(negedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < WORDS; i++) ram[i] = init_word(i);
      ram_ready = 1'b1;
    end
    if (ram_ce_n === 1'b0 && ram_we_n === 1'b0) ram[ram_a] = ram_di;
  end

  // Event monitors: ack/clr_done pulses, WE_N low-run length, A/DI stability.
  logic          rst_edge = 1'b1;
  logic [AW-1:0] pa;
  logic [DW-1:0] pd;
  logic          pwe;
  always @(posedge clk) rst_edge = !reset_n;
  always @(negedge clk) begin
    if (ack === 1'b1) ack_cnt++;
    if (clr_done === 1'b1) done_cnt++;
    if (ram_we_n === 1'b0) low_run++;
    else if (low_run != 0) begin
      last_low = low_run;
      low_run  = 0;
    end
    if (!rst_edge && (ram_a !== pa || ram_di !== pd) && (pwe !== 1'b1 || ram_we_n !== 1'b1)) begin
      mon_viol++;
      $display("FAIL addr_data_stable a %0h->%0h di %0h->%0h we_n %b->%b", pa, ram_a, pd, ram_di, pwe, ram_we_n);
    end
    pa  = ram_a;
    pd  = ram_di;
    pwe = ram_we_n;
  end

  // One request from IDLE; returns ack latency (-1 if none) and rdata at ack.
  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int lat, output logic [DW-1:0] rd);
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; wr = 1'($urandom_range(0, 1)); addr = AW'($urandom); wdata = DW'($urandom);
    lat = -1;
    rd  = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        lat = k;
        rd  = rdata;
        break;
      end
    end
    @(negedge clk);
    if (w) ref_mem[a] = d;
  endtask

  // Start a sweep (optionally with a simultaneous req) and wait for busy to drop.
  task automatic run_clear(input logic with_req, input logic [AW-1:0] a,
                           output int busy_cyc, output int acks, output int dones);
    int a0, d0;
    a0 = ack_cnt; d0 = done_cnt;
    clr = 1'b1; req = with_req; wr = 1'b1; addr = a; wdata = DW'($urandom);
    @(posedge clk); #1;
    clr = 1'b0; req = 1'b0;
    busy_cyc = 0;
    for (int k = 0; k < WORDS * 5 + 100; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cyc++;
      else break;
    end
    acks  = ack_cnt - a0;
    dones = done_cnt - d0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 1'b1; wr = 1'b1; clr = 1'b1; addr = '1; wdata = '1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack, busy, clr_done, ram_ce_n, ram_we_n} !== 5'b00011) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 00011", {ack, busy, clr_done, ram_ce_n, ram_we_n});
    end
    checks++;
    if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got %0h exp 0", rdata); end
    checks++;
    if (ram_a !== '0 || ram_di !== '0) begin
      errors++; $display("FAIL reset_a_di got %0h/%0h exp 0/0", ram_a, ram_di);
    end
    req = 1'b0; clr = 1'b0;
    reset_n = 1'b1;
    last_rd = '0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat;
    logic [DW-1:0] rd;
    do_req(1'b1, AW'('o1234), DW'('o7777), lat, rd);
    checks++;
    if (lat !== W_LAT) begin errors++; $display("FAIL wr_latency got %0d exp %0d", lat, W_LAT); end
    checks++;
    if (last_low !== WC) begin errors++; $display("FAIL we_n_width got %0d exp %0d", last_low, WC); end
    checks++;
    if (rd !== last_rd) begin errors++; $display("FAIL wr_keeps_rdata got %0h exp %0h", rd, last_rd); end
    do_req(1'b0, AW'('o1234), '0, lat, rd);
    checks++;
    if (lat !== R_LAT) begin errors++; $display("FAIL rd_latency got %0d exp %0d", lat, R_LAT); end
    checks++;
    if (rd !== DW'('o7777)) begin errors++; $display("FAIL rd_data got %0o exp 7777", rd); end
    last_rd = DW'('o7777);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [DW-1:0] rd, exp;
    logic w;
    logic [AW-1:0] a;
    do_req(1'b1, '0, DW'('o1111), lat, rd);
    do_req(1'b1, TOP, DW'('o2222), lat, rd);
    do_req(1'b0, '0, '0, lat, rd);
    checks++;
    if (rd !== DW'('o1111)) begin errors++; $display("FAIL b2b_rd0 got %0o exp 1111", rd); end
    do_req(1'b0, TOP, '0, lat, rd);
    checks++;
    if (rd !== DW'('o2222)) begin errors++; $display("FAIL b2b_rdtop got %0o exp 2222", rd); end
    last_rd = DW'('o2222);
    for (int i = 0; i < 24; i++) begin
      w   = 1'($urandom_range(0, 1));
      a   = AW'('o400 + $urandom_range(0, 15));
      exp = ref_mem[a];
      do_req(w, a, DW'($urandom), lat, rd);
      checks++;
      if (lat !== (w ? W_LAT : R_LAT)) begin
        errors++; $display("FAIL rand_latency i %0d wr %b got %0d", i, w, lat);
      end
      checks++;
      if (rd !== (w ? last_rd : exp)) begin
        errors++; $display("FAIL rand_rdata i %0d wr %b got %0h exp %0h", i, w, rd, w ? last_rd : exp);
      end
      if (!w) last_rd = exp;
    end
    checks++;
    if (mon_viol !== 0) begin errors++; $display("FAIL addr_stable_count got %0d exp 0", mon_viol); end
  endtask

  task automatic test_req_during_read();
    int lat, a0;
    logic [DW-1:0] rd;
    logic [AW-1:0] b;
    b  = AW'('o500);
    a0 = ack_cnt;
    req = 1'b1; wr = 1'b0; addr = AW'('o1234);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = b; wdata = ~ref_mem[b];
    @(posedge clk); #1;
    req = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (ack_cnt - a0 !== 1) begin errors++; $display("FAIL intrude_acks got %0d exp 1", ack_cnt - a0); end
    checks++;
    if (rdata !== ref_mem[AW'('o1234)]) begin
      errors++; $display("FAIL intrude_rdata got %0h exp %0h", rdata, ref_mem[AW'('o1234)]);
    end
    do_req(1'b0, b, '0, lat, rd);
    checks++;
    if (rd !== ref_mem[b]) begin errors++; $display("FAIL intrude_mem got %0h exp %0h", rd, ref_mem[b]); end
    last_rd = ref_mem[b];
  endtask

  task automatic test_clear();
    int lat, bc, acks, dones;
    logic [DW-1:0] rd;
    logic [AW-1:0] a;
    do_req(1'b1, AW'('o100), DW'('o5555), lat, rd);
    do_req(1'b1, TOP, DW'('o5555), lat, rd);
    run_clear(1'b0, '0, bc, acks, dones);
    checks++;
    if (bc !== WORDS * 5) begin errors++; $display("FAIL clr_busy got %0d exp %0d", bc, WORDS * 5); end
    checks++;
    if (acks !== 0 || dones !== 1) begin
      errors++; $display("FAIL clr_pulses got ack %0d done %0d exp 0 1", acks, dones);
    end
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? AW'('o100) : (i == 1) ? TOP : AW'($urandom);
      do_req(1'b0, a, '0, lat, rd);
      checks++;
      if (rd !== ref_mem[a]) begin errors++; $display("FAIL clr_mem a %0o got %0o exp 0", a, rd); end
    end
    last_rd = '0;
  endtask

  task automatic test_reset_mid_write();
    int lat, a0;
    logic [DW-1:0] rd;
    req = 1'b1; wr = 1'b1; addr = AW'('o300); wdata = DW'('o1234);
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ram_we_n !== 1'b0) begin errors++; $display("FAIL midrst_pre_we_n got %b exp 0", ram_we_n); end
    reset_n = 1'b0;
    a0 = ack_cnt;
    @(negedge clk);
    checks++;
    if ({ram_ce_n, ram_we_n, busy, ack} !== 4'b1100) begin
      errors++; $display("FAIL midrst_ctrl got %b exp 1100", {ram_ce_n, ram_we_n, busy, ack});
    end
    reset_n = 1'b1;
    last_rd = '0;
    repeat (8) @(negedge clk);
    checks++;
    if (ack_cnt !== a0) begin errors++; $display("FAIL midrst_ack got %0d exp %0d", ack_cnt - a0, 0); end
    do_req(1'b1, AW'('o42), DW'('o4321), lat, rd);
    checks++;
    if (lat !== W_LAT) begin errors++; $display("FAIL midrst_wr_lat got %0d exp %0d", lat, W_LAT); end
    do_req(1'b0, AW'('o42), '0, lat, rd);
    checks++;
    if (rd !== DW'('o4321)) begin errors++; $display("FAIL midrst_rd got %0o exp 4321", rd); end
    last_rd = DW'('o4321);
  endtask

  task automatic test_req_and_clr();
    int lat, bc, acks, dones;
    logic [DW-1:0] rd;
    run_clear(1'b1, AW'('o42), bc, acks, dones);
    checks++;
    if (acks !== 0 || dones !== 1) begin
      errors++; $display("FAIL both_pulses got ack %0d done %0d exp 0 1", acks, dones);
    end
    checks++;
    if (bc !== WORDS * 5) begin errors++; $display("FAIL both_busy got %0d exp %0d", bc, WORDS * 5); end
    do_req(1'b0, AW'('o42), '0, lat, rd);
    checks++;
    if (rd !== ref_mem[AW'('o42)]) begin errors++; $display("FAIL both_mem got %0o exp 0", rd); end
    checks++;
    if (mon_viol !== 0) begin errors++; $display("FAIL addr_stable_final got %0d exp 0", mon_viol); end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_req_during_read();
    test_clear();
    test_reset_mid_write();
    test_req_and_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
